computer_pio_in_snap: RTL and testbench



---
 rtl/computer_pio_pkg.sv | 14 +
 rtl/pio_sync_bank.sv | 28 ++
 rtl/computer_pio_in_snap.sv | 118 +++++++++++
 tb/tb_computer_pio_in_snap.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/computer_pio_pkg.sv
// computer_pio_pkg: shared register map and field constants for the PIO input snapshot block
package computer_pio_pkg;
    localparam int MAX_CH = 8;
    localparam logic [3:0] ADDR_CTRL      = 4'd0;
    localparam logic [3:0] ADDR_PERIOD    = 4'd1;
    localparam logic [3:0] ADDR_STATUS    = 4'd2;
    localparam logic [3:0] ADDR_IRQMASK   = 4'd3;
    localparam logic [3:0] ADDR_EDGECAP   = 4'd4;
    localparam logic [3:0] ADDR_SNAP_BASE = 4'd8;
    localparam int CTRL_SNAP_BIT     = 0;
    localparam int CTRL_AUTO_BIT     = 1;
    localparam int STATUS_SVALID_BIT = 0;
    localparam int STATUS_IRQ_BIT    = 1;
endpackage

// File: rtl/pio_sync_bank.sv
// pio_sync_bank: STAGES-deep flop synchroniser over a W-bit bus (STAGES=0 is a wire)
// Ports: clk, reset_n (async active-low), d_in (asynchronous bus), sync_out (synchronised bus)
module pio_sync_bank #(
    parameter int W      = 96,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] sync_out
);
    generate
        if (STAGES == 0) begin : g_bypass
            assign sync_out = d_in;
        end else begin : g_sync
            logic [STAGES-1:0][W-1:0] stage_q, stage_d;
            always_comb begin
                stage_d[0] = d_in;
                for (int s = 1; s < STAGES; s++) stage_d[s] = stage_q[s-1];
            end
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) stage_q <= '0;
                else          stage_q <= stage_d;
            end
            assign sync_out = stage_q[STAGES-1];
        end
    endgenerate
endmodule

// File: rtl/computer_pio_in_snap.sv
// computer_pio_in_snap: multi-channel Avalon-MM input PIO with coherent snapshots and edge irq
// Ports: clk, reset_n (async active-low); Avalon slave address/chipselect/read/write/
//        writedata/readdata (1-cycle registered read); in_port (NUM_CH x DATA_W); irq (level)
module computer_pio_in_snap
    import computer_pio_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_CH      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int PERIOD_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [3:0]               address,
    input  logic                     chipselect,
    input  logic                     read,
    input  logic                     write,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    input  logic [NUM_CH*DATA_W-1:0] in_port,
    output logic                     irq
);
    localparam int BUS_W = NUM_CH * DATA_W;

    logic [BUS_W-1:0] sync_q;
    logic [BUS_W-1:0] prev_q;
    logic [NUM_CH-1:0][DATA_W-1:0] snap_q, snap_d;
    logic [PERIOD_W-1:0] period_q, period_d, cnt_q, cnt_d;
    logic [NUM_CH-1:0] mask_q, mask_d, edgecap_q, edgecap_d, ch_chg;
    logic auto_q, auto_d, svalid_q, svalid_d, irq_q, irq_d;
    logic [31:0] rdata_q, rdata_d, rsel;
    logic [MAX_CH-1:0][31:0] snap_ext;
    logic wr_en, rd_en, wr_ctrl, wr_period, wr_mask, wr_edgecap, rd_status, tc, snap_fire;
    logic unused_wdata;

    pio_sync_bank #(.W(BUS_W), .STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .d_in     (in_port),
        .sync_out (sync_q)
    );

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_chg
            assign ch_chg[c] = sync_q[c*DATA_W +: DATA_W] != prev_q[c*DATA_W +: DATA_W];
        end
        // Pad the snapshot bank to MAX_CH words so the read mux never indexes past NUM_CH
        for (c = 0; c < MAX_CH; c++) begin : g_ext
            if (c < NUM_CH) begin : g_live
                assign snap_ext[c] = 32'(snap_q[c]);
            end else begin : g_zero
                assign snap_ext[c] = '0;
            end
        end
    endgenerate

    assign unused_wdata = ^writedata;
    assign wr_en      = chipselect & write;
    assign rd_en      = chipselect & read;
    assign wr_ctrl    = wr_en && address == ADDR_CTRL;
    assign wr_period  = wr_en && address == ADDR_PERIOD;
    assign wr_mask    = wr_en && address == ADDR_IRQMASK;
    assign wr_edgecap = wr_en && address == ADDR_EDGECAP;
    assign rd_status  = rd_en && address == ADDR_STATUS;
    assign tc         = auto_q && cnt_q == period_q;
    // A strobe coinciding with terminal count still yields just one load of the bank
    assign snap_fire  = (wr_ctrl && writedata[CTRL_SNAP_BIT]) || tc;

    always_comb begin
        rsel = address == ADDR_CTRL    ? 32'(auto_q) << CTRL_AUTO_BIT :
               address == ADDR_PERIOD  ? 32'(period_q) :
               address == ADDR_STATUS  ? (32'(irq_q) << STATUS_IRQ_BIT) | (32'(svalid_q) << STATUS_SVALID_BIT) :
               address == ADDR_IRQMASK ? 32'(mask_q) :
               address == ADDR_EDGECAP ? 32'(edgecap_q) :
               address >= ADDR_SNAP_BASE ? snap_ext[address[2:0]] : '0;
        rdata_d   = rd_en ? rsel : rdata_q;
        auto_d    = wr_ctrl ? writedata[CTRL_AUTO_BIT] : auto_q;
        period_d  = wr_period ? writedata[PERIOD_W-1:0] : period_q;
        cnt_d     = (wr_ctrl || wr_period || !auto_q || tc) ? '0 : cnt_q + PERIOD_W'(1);
        // A snapshot on the same edge as a STATUS read wins: the read sees the old 0
        svalid_d  = snap_fire | (svalid_q & ~rd_status);
        mask_d    = wr_mask ? writedata[NUM_CH-1:0] : mask_q;
        // OR-ing the new edges after the W1C clear makes set win a collision
        edgecap_d = (edgecap_q & ~(wr_edgecap ? writedata[NUM_CH-1:0] : '0)) | ch_chg;
        irq_d     = |(edgecap_q & mask_q);
        snap_d    = snap_fire ? sync_q : snap_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q    <= '0;
            snap_q    <= '0;
            period_q  <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
            edgecap_q <= '0;
            auto_q    <= 1'b0;
            svalid_q  <= 1'b0;
            irq_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            prev_q    <= sync_q;
            snap_q    <= snap_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            edgecap_q <= edgecap_d;
            auto_q    <= auto_d;
            svalid_q  <= svalid_d;
            irq_q     <= irq_d;
            rdata_q   <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_computer_pio_in_snap.sv
// tb_computer_pio_in_snap: directed self-checking bench for computer_pio_in_snap
module tb_computer_pio_in_snap;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [3:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [95:0] in_port = '0;
    logic [95:0] in_port2 = '0;
    logic [31:0] readdata, readdata2;
    logic        irq, irq2;
    logic [31:0] v;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    computer_pio_in_snap dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    computer_pio_in_snap #(.DATA_W(12), .NUM_CH(8)) dut_w (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata2),
        .in_port(in_port2), .irq(irq2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick();
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), v);
            check($sformatf("reset_rd%0d", a), v, 32'h0);
        end
        check("reset_irq", {31'b0, irq}, 32'h0);

        in_port = {32'h33, 32'h22, 32'h11};
        repeat (3) tick();
        wr(4'd0, 32'h1);
        in_port = {32'hCC, 32'hBB, 32'hAA};
        rd(4'd8, v);  check("snap0", v, 32'h11);
        rd(4'd9, v);  check("snap1", v, 32'h22);
        rd(4'd10, v); check("snap2", v, 32'h33);
        rd(4'd2, v);  check("svalid_set", v, 32'h1);
        rd(4'd2, v);  check("svalid_clr", v, 32'h0);

        wr(4'd1, 32'd9);
        in_port[31:0] = 32'h0;
        wr(4'd0, 32'h2);
        chipselect = 1'b1; read = 1'b1; address = 4'd8;
        for (int j = 1; j <= 45; j++) begin
            @(posedge clk);
            #1;
            in_port[31:0] = 32'(j);
            check($sformatf("auto_j%0d", j), readdata, j < 11 ? 32'h11 : 32'(10 * ((j - 1) / 10) - 3));
        end
        chipselect = 1'b0; read = 1'b0;
        wr(4'd0, 32'h0);
        for (int j = 0; j < 15; j++) begin
            tick();
            in_port[31:0] = 32'(100 + j);
        end
        rd(4'd8, v); check("auto_stopped", v, 32'd37);
        rd(4'd0, v); check("ctrl_rd", v, 32'h0);
        rd(4'd1, v); check("period_rd", v, 32'd9);

        repeat (4) tick();
        wr(4'd4, 32'h7);
        wr(4'd3, 32'h2);
        rd(4'd4, v); check("edge_clr", v, 32'h0);
        check("irq_idle", {31'b0, irq}, 32'h0);
        in_port[32] = ~in_port[32];
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("irq_lat%0d", k), {31'b0, irq}, k >= 4 ? 32'h1 : 32'h0);
        end
        in_port[0] = ~in_port[0];
        repeat (4) tick();
        rd(4'd4, v); check("edge_ch0", v, 32'h3);
        check("irq_ch0", {31'b0, irq}, 32'h1);
        wr(4'd4, 32'h2);
        check("irq_hold", {31'b0, irq}, 32'h1);
        tick();
        check("irq_drop", {31'b0, irq}, 32'h0);
        rd(4'd4, v); check("edge_w1c", v, 32'h1);

        in_port[32] = ~in_port[32];
        tick();
        tick();
        wr(4'd4, 32'h2);
        rd(4'd4, v); check("collide", v, 32'h3);
        check("collide_irq", {31'b0, irq}, 32'h1);

        for (int i = 0; i < 7; i++) in_port2[i*12 +: 12] = 12'(i + 1);
        in_port2[84 +: 12] = 12'hABC;
        repeat (3) tick();
        wr(4'd0, 32'h1);
        rd(4'd15, v);
        check("w_snap7", readdata2, 32'h0000_0ABC);
        check("n_snap15", v, 32'h0);
        rd(4'd4, v); check("w_edge", readdata2, 32'h0000_00FF);
        rd(4'd9, v); check("w_snap1", readdata2, 32'h2);

        in_port = {32'h5, 32'h6, 32'h7};
        reset_n = 1'b0;
        #2;
        check("arst_rdata", readdata, 32'h0);
        check("arst_irq", {31'b0, irq}, 32'h0);
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        rd(4'd4, v); check("post_rst_edge", v, 32'h7);
        rd(4'd8, v); check("post_rst_snap", v, 32'h0);
        rd(4'd3, v); check("post_rst_mask", v, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
